// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the IF and MEM pipeline stages.
// Optional IF starvation guard enabled by defining MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IF_Req,
    input  logic [ADDR_WIDTH-1:0]   IF_Addr,
    output logic [DATA_WIDTH-1:0]   IF_Instr,
    output logic                    IF_Valid,
    output logic                    IF_Stall,
    input  logic                    MEM_Req,
    input  logic                    MEM_Write,
    input  logic [ADDR_WIDTH-1:0]   MEM_Addr,
    input  logic [DATA_WIDTH-1:0]   MEM_WData,
    input  logic [DATA_WIDTH/8-1:0] MEM_WStrb,
    output logic [DATA_WIDTH-1:0]   MEM_RData,
    output logic                    MEM_Valid,
    output logic                    MEM_Stall,
    output logic                    Mem_En,
    output logic [DATA_WIDTH/8-1:0] Mem_WE,
    output logic [ADDR_WIDTH-1:0]   Mem_Addr,
    output logic [DATA_WIDTH-1:0]   Mem_WData,
    input  logic [DATA_WIDTH-1:0]   Mem_RData,
    input  logic                    Mem_Ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   grant_if_s;
    logic   grant_mem_s;
    logic   done_s;
    logic   force_if_s;
    logic   wr_r;

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_cnt_r;

    assign force_if_s = IF_Req && (starve_cnt_r == LIMIT_C);

    // Counts MEM grants made while IF is waiting; any IF grant or idle IF clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (grant_if_s || ((state_r == IDLE) && !IF_Req)) begin
            starve_cnt_r <= '0;
        end else if (grant_mem_s && IF_Req) begin
            starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign force_if_s = 1'b0;
`endif

    // Stalls are combinational so they line up with the load-use stall in the hazard unit.
    assign IF_Stall  = IF_Req && !IF_Valid;
    assign MEM_Stall = MEM_Req && !MEM_Valid;

    // Next-state and grant decode.
    always_comb begin
        state_nxt_s = state_r;
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (MEM_Req && !force_if_s) begin
                    grant_mem_s = 1'b1;
                    state_nxt_s = BUSY_MEM;
                end else if (IF_Req) begin
                    grant_if_s  = 1'b1;
                    state_nxt_s = BUSY_IF;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (Mem_Ready) begin
                    done_s      = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus latched memory request and registered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            Mem_En    <= 1'b0;
            Mem_WE    <= '0;
            Mem_Addr  <= '0;
            Mem_WData <= '0;
            IF_Instr  <= '0;
            MEM_RData <= '0;
            IF_Valid  <= 1'b0;
            MEM_Valid <= 1'b0;
            wr_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            IF_Valid  <= 1'b0;
            MEM_Valid <= 1'b0;
            if (grant_mem_s) begin
                Mem_En    <= 1'b1;
                Mem_Addr  <= MEM_Addr;
                Mem_WData <= MEM_WData;
                Mem_WE    <= MEM_Write ? MEM_WStrb : '0;
                wr_r      <= MEM_Write;
            end else if (grant_if_s) begin
                Mem_En   <= 1'b1;
                Mem_Addr <= IF_Addr;
                Mem_WE   <= '0;
                wr_r     <= 1'b0;
            end else if (done_s) begin
                Mem_En <= 1'b0;
                Mem_WE <= '0;
                if (state_r == BUSY_IF) begin
                    IF_Valid <= 1'b1;
                    IF_Instr <= Mem_RData;
                end else begin
                    MEM_Valid <= 1'b1;
                    // Stores leave the last load data untouched.
                    if (!wr_r) begin
                        MEM_RData <= Mem_RData;
                    end else begin
                        MEM_RData <= MEM_RData;
                    end
                end
            end else begin
                Mem_En <= Mem_En;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; grant-order check follows MEM_ARB_FAIR_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic [31:0] IF_Instr;
    logic        IF_Valid;
    logic        IF_Stall;
    logic        MEM_Req;
    logic        MEM_Write;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_WData;
    logic [3:0]  MEM_WStrb;
    logic [31:0] MEM_RData;
    logic        MEM_Valid;
    logic        MEM_Stall;
    logic        Mem_En;
    logic [3:0]  Mem_WE;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;
    logic        Mem_Ready;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Instr(IF_Instr),
        .IF_Valid(IF_Valid), .IF_Stall(IF_Stall),
        .MEM_Req(MEM_Req), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr),
        .MEM_WData(MEM_WData), .MEM_WStrb(MEM_WStrb), .MEM_RData(MEM_RData),
        .MEM_Valid(MEM_Valid), .MEM_Stall(MEM_Stall),
        .Mem_En(Mem_En), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ready(Mem_Ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] grants [5];
        logic [31:0] exp_g;
        int          ng;

        rst = 1'b1;
        IF_Req = $urandom_range(1, 0); IF_Addr = $urandom;
        MEM_Req = $urandom_range(1, 0); MEM_Write = $urandom_range(1, 0);
        MEM_Addr = $urandom; MEM_WData = $urandom; MEM_WStrb = 4'($urandom);
        Mem_RData = $urandom; Mem_Ready = $urandom_range(1, 0);
        step();
        step();
        rst = 1'b0;
        IF_Req = 1'b0; MEM_Req = 1'b0; MEM_Write = 1'b0; Mem_Ready = 1'b0;
        IF_Addr = 32'h0; MEM_Addr = 32'h0; MEM_WData = 32'h0; MEM_WStrb = 4'h0;
        #1;
        chk("rst_mem_en",    {31'd0, Mem_En},    32'd0);
        chk("rst_mem_we",    {28'd0, Mem_WE},    32'd0);
        chk("rst_if_valid",  {31'd0, IF_Valid},  32'd0);
        chk("rst_mem_valid", {31'd0, MEM_Valid}, 32'd0);
        chk("rst_mem_addr",  Mem_Addr,           32'd0);
        chk("rst_mem_wdata", Mem_WData,          32'd0);
        chk("rst_if_instr",  IF_Instr,           32'd0);
        chk("rst_mem_rdata", MEM_RData,          32'd0);
        chk("rst_stalls",    {30'd0, IF_Stall, MEM_Stall}, 32'd0);

        // IF read with ready tied high
        IF_Req = 1'b1; IF_Addr = 32'h100; Mem_Ready = 1'b1; Mem_RData = 32'h00500093;
        #1;
        chk("if_stall_comb", {31'd0, IF_Stall}, 32'd1);
        step();
        chk("if_en",   {31'd0, Mem_En}, 32'd1);
        chk("if_addr", Mem_Addr,        32'h100);
        chk("if_we",   {28'd0, Mem_WE}, 32'd0);
        step();
        chk("if_valid",     {31'd0, IF_Valid}, 32'd1);
        chk("if_instr",     IF_Instr,          32'h00500093);
        chk("if_en_drop",   {31'd0, Mem_En},   32'd0);
        chk("if_stall_off", {31'd0, IF_Stall}, 32'd0);
        IF_Req = 1'b0;
        step();
        chk("if_valid_pulse", {31'd0, IF_Valid}, 32'd0);
        chk("if_resp_no_en",  {31'd0, Mem_En},   32'd0);

        // Collision: MEM load wins, 3-cycle memory latency, then IF
        IF_Req = 1'b1; IF_Addr = 32'h104;
        MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Addr = 32'h2000;
        Mem_Ready = 1'b0; Mem_RData = 32'hDEADBEEF;
        step();
        chk("col_mem_first", Mem_Addr, 32'h2000);
        MEM_Addr = 32'h5555;
        step();
        chk("col_en_held",   {31'd0, Mem_En},    32'd1);
        chk("col_addr_held", Mem_Addr,           32'h2000);
        chk("col_mem_stall", {31'd0, MEM_Stall}, 32'd1);
        step();
        Mem_Ready = 1'b1;
        step();
        chk("col_mem_valid", {31'd0, MEM_Valid}, 32'd1);
        chk("col_mem_rdata", MEM_RData,          32'hDEADBEEF);
        chk("col_if_wait",   {31'd0, IF_Stall},  32'd1);
        MEM_Req = 1'b0; Mem_Ready = 1'b0;
        step();
        chk("col_resp_no_en", {31'd0, Mem_En}, 32'd0);
        Mem_Ready = 1'b1; Mem_RData = 32'h00A00113;
        step();
        chk("col_if_grant", Mem_Addr,        32'h104);
        chk("col_if_en",    {31'd0, Mem_En}, 32'd1);
        step();
        chk("col_if_valid", {31'd0, IF_Valid}, 32'd1);
        chk("col_if_instr", IF_Instr,          32'h00A00113);
        IF_Req = 1'b0; Mem_Ready = 1'b0;
        step();

        // Store with partial strobe; requester inputs change after grant
        MEM_Req = 1'b1; MEM_Write = 1'b1; MEM_Addr = 32'h2004;
        MEM_WData = 32'h11223344; MEM_WStrb = 4'b0011; Mem_RData = 32'hCAFEF00D;
        step();
        MEM_WStrb = 4'b1111; MEM_WData = 32'h0; MEM_Addr = 32'h0;
        chk("st_we",    {28'd0, Mem_WE}, 32'h3);
        chk("st_wdata", Mem_WData,       32'h11223344);
        chk("st_addr",  Mem_Addr,        32'h2004);
        step();
        chk("st_we_held", {28'd0, Mem_WE}, 32'h3);
        Mem_Ready = 1'b1;
        step();
        chk("st_valid",      {31'd0, MEM_Valid}, 32'd1);
        chk("st_rdata_keep", MEM_RData,          32'hDEADBEEF);
        chk("st_we_clear",   {28'd0, Mem_WE},    32'd0);
        MEM_Req = 1'b0; MEM_Write = 1'b0; Mem_Ready = 1'b0;
        step();

        // Reset in the second BUSY_MEM cycle
        MEM_Req = 1'b1; MEM_Addr = 32'h3000;
        step();
        step();
        rst = 1'b1; Mem_Ready = 1'b1;
        step();
        chk("rm_en_drop",  {31'd0, Mem_En},    32'd0);
        chk("rm_no_valid", {31'd0, MEM_Valid}, 32'd0);
        rst = 1'b0; MEM_Req = 1'b0;
        step();
        chk("rm_no_valid2", {31'd0, MEM_Valid}, 32'd0);
        chk("rm_rdata_rst", MEM_RData,          32'd0);
        Mem_Ready = 1'b0;
        step();

        // Starvation: both requests held continuously, ready tied high
        MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Addr = 32'h4000;
        IF_Req = 1'b1; IF_Addr = 32'h200; Mem_Ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            step();
            if (Mem_En) begin
                grants[ng] = Mem_Addr;
                ng++;
            end
        end
        chk("fair_grant_count", ng, 32'd5);
        for (int g = 0; g < ng; g++) begin
`ifdef MEM_ARB_FAIR_EN
            exp_g = (g == 4) ? 32'h200 : 32'h4000;
`else
            exp_g = 32'h4000;
`endif
            chk($sformatf("grant_%0d", g), grants[g], exp_g);
        end
        MEM_Req = 1'b0; IF_Req = 1'b0; Mem_Ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, variable-latency memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the pipeline. A registered FSM grants the port, holds the memory request stable until the memory acknowledges, and returns the result with a one-cycle valid pulse. It also drives per-stage stall outputs that sit alongside the load-use stall in the hazard logic. MEM wins simultaneous requests, and an optional starvation guard protects IF.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width; `DATA_WIDTH/8` strobe bits.
- `STARVE_LIMIT`, 4, consecutive MEM grants allowed while IF waits; guard only.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `IF_Req` in 1: fetch request, held until `IF_Valid`.
- `IF_Addr` in ADDR_WIDTH: fetch address.
- `IF_Instr` out DATA_WIDTH: last fetched word, registered.
- `IF_Valid` out 1: one-cycle fetch completion pulse.
- `IF_Stall` out 1: `IF_Req && !IF_Valid`.
- `MEM_Req` in 1: data request (MemRead|MemWrite), held until `MEM_Valid`.
- `MEM_Write` in 1: 1 = store.
- `MEM_Addr` in ADDR_WIDTH; `MEM_WData` in DATA_WIDTH; `MEM_WStrb` in DATA_WIDTH/8.
- `MEM_RData` out DATA_WIDTH: last load data, registered.
- `MEM_Valid` out 1: one-cycle data completion pulse.
- `MEM_Stall` out 1: `MEM_Req && !MEM_Valid`.
- `Mem_En` out 1: memory request, held until ready.
- `Mem_WE` out DATA_WIDTH/8: byte write enables, all zero for reads.
- `Mem_Addr` out ADDR_WIDTH; `Mem_WData` out DATA_WIDTH.
- `Mem_RData` in DATA_WIDTH; `Mem_Ready` in 1: completes the current access when sampled with `Mem_En`.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE:
  - `MEM_Req` → BUSY_MEM; else `IF_Req` → BUSY_IF; else stay.
  - On grant, latch address, wdata and strobe into the `Mem_*` registers.
- BUSY_x:
  - `Mem_En`=1; `Mem_WE`=`MEM_WStrb` for a MEM store, else 0.
  - Requester inputs are ignored after the grant; the latched values stay stable.
  - On `Mem_Ready`=1: read completions capture `Mem_RData` into `IF_Instr`/`MEM_RData`; store completions leave `MEM_RData` unchanged. Next state RESP, remembering the owner.
- RESP:
  - Owner's `*_Valid`=1, `Mem_En`=0, no grant; next state IDLE.
  - This gives the stage one edge to advance so the held request is not re-issued.
- `Mem_Ready` is ignored outside BUSY states.
- Reset values:
  - State IDLE.
  - `Mem_En`, `Mem_WE`, `IF_Valid`, `MEM_Valid` = 0.
  - `Mem_Addr`, `Mem_WData`, `IF_Instr`, `MEM_RData` = 0.
  - Starve counter = 0.
- Reset mid-access: next edge returns to IDLE, drops `Mem_En`, and produces no `*_Valid` for the aborted access.

## Timing
- Request sampled in IDLE at cycle t → `Mem_En`=1 from t+1.
- `Mem_Ready` first seen at cycle t+k (k≥1) → `*_Valid` at t+k+1 → IDLE at t+k+2.
- Minimum request-to-valid latency is 2 cycles (`Mem_Ready` tied high); back-to-back issue interval is 3 cycles minimum.
- Simultaneous `IF_Req` and `MEM_Req` in IDLE: MEM is served first. IF is granted in the IDLE cycle after MEM's RESP if `MEM_Req` is low then.
- Stall outputs are combinational from inputs and registered valids; no added latency.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A 3-bit-minimum counter increments on each MEM grant made while `IF_Req`=1.
  - It clears on any IF grant or when `IF_Req`=0 in IDLE.
  - When counter == `STARVE_LIMIT` and `IF_Req`=1, IDLE grants IF even if `MEM_Req`=1.
- Undefined: strict MEM priority, no counter logic.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs 0, state IDLE, `Mem_En`=0.
- IF read, `Mem_Ready` tied 1: `IF_Addr`=0x100, mem returns 0x00500093 → `Mem_En` 1 cycle at 0x100; `IF_Valid` at t+2; `IF_Instr`=0x00500093.
- Collision: `IF_Req` and `MEM_Req` (load 0x2000→0xDEADBEEF) in the same cycle, 3-cycle memory latency → MEM served first (`MEM_Valid` at t+4, `MEM_RData`=0xDEADBEEF), then IF granted.
- Store: `MEM_Write`=1, addr 0x2004, wdata 0x11223344, strb 0b0011 → `Mem_WE`=0011 held until ready; `MEM_Valid` pulses; `MEM_RData` unchanged.
- Reset mid-access: `rst` at BUSY_MEM cycle 2, then `Mem_Ready`=1 → no `MEM_Valid`; `Mem_En`=0 after the edge.
- `MEM_ARB_FAIR_EN`, `STARVE_LIMIT`=4: `MEM_Req` continuous and `IF_Req` continuous → grant order MEM,MEM,MEM,MEM,IF; without the macro, IF never granted.
